// File: rtl/frame_fifo_pkg.sv
// Shared FSM encoding, constants and buffer-index clamp for the multi-buffer frame writer.
package frame_fifo_pkg;

    localparam logic ONE  = 1'b1;
    localparam logic ZERO = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ACK         = 3'd1,
        ST_CHECK_FIFO  = 3'd2,
        ST_WRITE_BURST = 3'd3,
        ST_BURST_END   = 3'd4,
        ST_END         = 3'd5
    } state_t;

    // Out-of-range buffer indices fall back to the last real buffer.
    function automatic int unsigned clamp_idx(input int unsigned idx, input int unsigned buf_num);
        return (idx >= buf_num) ? buf_num - 1 : idx;
    endfunction

endpackage

// File: rtl/frame_req_sync.sv
// Three-flop synchroniser bringing frame-start controls into the mem_clk domain.
module frame_req_sync #(
    parameter int WIDTH = 1
) (
    input  logic             rst,
    input  logic             mem_clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1;
    logic [WIDTH-1:0] stage2;

    // NOTE: non-blocking assignments make each stage capture its predecessor's old value, forming a true shift chain.
    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            stage1 <= '0;
            stage2 <= '0;
            q      <= '0;
        end else begin
            stage1 <= d;
            stage2 <= stage1;
            q      <= stage2;
        end
    end

endmodule

// File: rtl/frame_fifo_write_mb.sv
// Multi-buffer frame write engine: drains the input FIFO into memory as bursts.
// Define FRAME_WR_TAIL_BURST_EN to allow a short final burst for non-multiple frame lengths.
module frame_fifo_write_mb
    import frame_fifo_pkg::*;
#(
    parameter int                    MEM_DATA_BITS = 32,
    parameter int                    ADDR_BITS     = 23,
    parameter int                    BURST_BITS    = 10,
    parameter int                    BURST_SIZE    = 256,
    parameter int                    BUF_NUM       = 4,
    parameter int                    IDX_BITS      = 2,
    parameter logic [ADDR_BITS-1:0]  FRAME_STRIDE  = ADDR_BITS'(32'h0008_0000),
    parameter int                    CNT_BITS      = 16
) (
    input  logic                  rst,
    input  logic                  mem_clk,
    input  logic                  write_req,
    output logic                  write_req_ack,
    output logic                  write_finish,
    output logic                  frame_abort,
    output logic                  busy,
    input  logic [ADDR_BITS-1:0]  write_base,
    input  logic [IDX_BITS-1:0]   write_buf_index,
    input  logic [ADDR_BITS-1:0]  write_len,
    input  logic [CNT_BITS-1:0]   rd_data_count,
    output logic                  fifo_aclr,
    output logic                  wr_burst_req,
    output logic [BURST_BITS-1:0] wr_burst_len,
    output logic [ADDR_BITS-1:0]  wr_burst_addr,
    input  logic                  wr_burst_data_req,
    input  logic                  wr_burst_finish
);

    if (MEM_DATA_BITS < 1) begin : g_bad_data_bits
        $error("MEM_DATA_BITS must be positive");
    end
    if (BURST_SIZE >= (1 << BURST_BITS)) begin : g_bad_burst_size
        $error("BURST_SIZE must fit in BURST_BITS");
    end
    if (BUF_NUM < 2 || (1 << IDX_BITS) < BUF_NUM) begin : g_bad_buf_num
        $error("BUF_NUM must be >= 2 and addressable by IDX_BITS");
    end

    state_t                state;
    state_t                state_next;
    logic                  req_s;
    logic [IDX_BITS-1:0]   idx_s;
    logic [ADDR_BITS-1:0]  len_s;
    logic [ADDR_BITS-1:0]  len_latch;
    logic [ADDR_BITS-1:0]  write_cnt;
    logic [ADDR_BITS-1:0]  remaining;
    logic [ADDR_BITS-1:0]  buf_addr;
    logic [31:0]           burst_len_next;
    logic                  fill_ok;
    logic                  launch;
    logic                  mid_frame;

    frame_req_sync #(.WIDTH(1)) u_req_sync (
        .rst     (rst),
        .mem_clk (mem_clk),
        .d       (write_req),
        .q       (req_s)
    );

    frame_req_sync #(.WIDTH(IDX_BITS)) u_idx_sync (
        .rst     (rst),
        .mem_clk (mem_clk),
        .d       (write_buf_index),
        .q       (idx_s)
    );

    frame_req_sync #(.WIDTH(ADDR_BITS)) u_len_sync (
        .rst     (rst),
        .mem_clk (mem_clk),
        .d       (write_len),
        .q       (len_s)
    );

    assign remaining = len_latch - write_cnt;
    assign buf_addr  = write_base + ADDR_BITS'(clamp_idx(32'(idx_s), BUF_NUM)) * FRAME_STRIDE;
    assign mid_frame = (write_cnt != '0) && (write_cnt < len_latch);

    always_comb begin
`ifdef FRAME_WR_TAIL_BURST_EN
        burst_len_next = (32'(remaining) < 32'(BURST_SIZE)) ? 32'(remaining) : 32'(BURST_SIZE);
`else
        burst_len_next = 32'(BURST_SIZE);
`endif
    end

    assign fill_ok = (32'(rd_data_count) >= burst_len_next);
    assign launch  = (state == ST_CHECK_FIFO) && !req_s && (remaining != '0) && fill_ok;

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next defaults to the current state so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_s) state_next = ST_ACK;
            end
            ST_ACK: begin
                if (!req_s) state_next = ST_CHECK_FIFO;
            end
            ST_CHECK_FIFO: begin
                if (req_s)                 state_next = ST_ACK;
                else if (remaining == '0)  state_next = ST_END;
                else if (launch)           state_next = ST_WRITE_BURST;
            end
            ST_WRITE_BURST: begin
                if (wr_burst_finish) state_next = ST_BURST_END;
            end
            ST_BURST_END: begin
                if (req_s)                       state_next = ST_ACK;
                else if (write_cnt < len_latch)  state_next = ST_CHECK_FIFO;
                else                             state_next = ST_END;
            end
            ST_END: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        write_req_ack = ZERO;
        fifo_aclr     = ZERO;
        write_finish  = ZERO;
        frame_abort   = ZERO;
        busy          = ONE;
        case (state)
            ST_IDLE: begin
                busy = ZERO;
            end
            ST_ACK: begin
                write_req_ack = ONE;
                fifo_aclr     = ONE;
            end
            ST_CHECK_FIFO: begin
                frame_abort = req_s && mid_frame;
            end
            ST_BURST_END: begin
                frame_abort = req_s;
            end
            ST_END: begin
                write_finish = ONE;
            end
            default: begin
                busy = ONE;
            end
        endcase
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            wr_burst_req  <= ZERO;
            wr_burst_len  <= '0;
            wr_burst_addr <= '0;
            write_cnt     <= '0;
            len_latch     <= '0;
        end else begin
            if (state == ST_ACK && req_s) begin
                wr_burst_addr <= buf_addr;
                len_latch     <= len_s;
                write_cnt     <= '0;
            end
            if (launch) begin
                wr_burst_len <= BURST_BITS'(burst_len_next);
                wr_burst_req <= ONE;
            end
            if (state == ST_WRITE_BURST) begin
                // A finish without a prior data request still retires the request.
                if (wr_burst_data_req || wr_burst_finish) wr_burst_req <= ZERO;
                if (wr_burst_finish) begin
                    write_cnt     <= write_cnt + ADDR_BITS'(wr_burst_len);
                    wr_burst_addr <= wr_burst_addr + ADDR_BITS'(wr_burst_len);
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_fifo_write_mb.sv
// Self-checking bench for frame_fifo_write_mb; expected bursts come from a frame-level model.
`timescale 1ns/1ps
module tb_frame_fifo_write_mb;

    localparam int ADDR_BITS  = 23;
    localparam int BURST_BITS = 10;
    localparam int BURST_SIZE = 256;
    localparam int BUF_NUM    = 3;
    localparam int IDX_BITS   = 2;
    localparam int CNT_BITS   = 16;
    localparam logic [ADDR_BITS-1:0] STRIDE = 23'h080000;
    localparam int unsigned ADDR_MASK = (32'd1 << ADDR_BITS) - 1;
`ifdef FRAME_WR_TAIL_BURST_EN
    localparam bit TAIL_EN = 1'b1;
`else
    localparam bit TAIL_EN = 1'b0;
`endif

    logic                  rst;
    logic                  mem_clk;
    logic                  write_req;
    logic                  write_req_ack;
    logic                  write_finish;
    logic                  frame_abort;
    logic                  busy;
    logic [ADDR_BITS-1:0]  write_base;
    logic [IDX_BITS-1:0]   write_buf_index;
    logic [ADDR_BITS-1:0]  write_len;
    logic [CNT_BITS-1:0]   rd_data_count;
    logic                  fifo_aclr;
    logic                  wr_burst_req;
    logic [BURST_BITS-1:0] wr_burst_len;
    logic [ADDR_BITS-1:0]  wr_burst_addr;
    logic                  wr_burst_data_req;
    logic                  wr_burst_finish;

    frame_fifo_write_mb #(
        .ADDR_BITS    (ADDR_BITS),
        .BURST_BITS   (BURST_BITS),
        .BURST_SIZE   (BURST_SIZE),
        .BUF_NUM      (BUF_NUM),
        .IDX_BITS     (IDX_BITS),
        .FRAME_STRIDE (STRIDE),
        .CNT_BITS     (CNT_BITS)
    ) dut (
        .rst               (rst),
        .mem_clk           (mem_clk),
        .write_req         (write_req),
        .write_req_ack     (write_req_ack),
        .write_finish      (write_finish),
        .frame_abort       (frame_abort),
        .busy              (busy),
        .write_base        (write_base),
        .write_buf_index   (write_buf_index),
        .write_len         (write_len),
        .rd_data_count     (rd_data_count),
        .fifo_aclr         (fifo_aclr),
        .wr_burst_req      (wr_burst_req),
        .wr_burst_len      (wr_burst_len),
        .wr_burst_addr     (wr_burst_addr),
        .wr_burst_data_req (wr_burst_data_req),
        .wr_burst_finish   (wr_burst_finish)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] len;
    } burst_t;

    int          tests = 0;
    int          fails = 0;
    burst_t      exp_q[$];
    bit          exp_stall;
    int unsigned exp_start;
    int unsigned exp_words;
    int unsigned nb_base;
    int unsigned nb_idx;
    int unsigned nb_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge mem_clk);
    endtask

    // Frame-level model: full bursts from the buffer start, then an optional tail.
    task automatic model_frame(input int unsigned base, input int unsigned idx, input int unsigned len);
        int unsigned b;
        int unsigned nfull;
        int unsigned tail;
        exp_q.delete();
        b         = (idx >= BUF_NUM) ? BUF_NUM - 1 : idx;
        exp_start = (base + b * 32'(STRIDE)) & ADDR_MASK;
        nfull     = len / BURST_SIZE;
        tail      = len % BURST_SIZE;
        exp_words = nfull * BURST_SIZE;
        for (int i = 0; i < int'(nfull); i++)
            exp_q.push_back('{addr: (exp_start + i * BURST_SIZE) & ADDR_MASK, len: BURST_SIZE});
        exp_stall = (tail != 0) && !TAIL_EN;
        if (tail != 0 && TAIL_EN) begin
            exp_q.push_back('{addr: (exp_start + exp_words) & ADDR_MASK, len: tail});
            exp_words += tail;
        end
    endtask

    task automatic start_frame(input int unsigned base, input int unsigned idx, input int unsigned len,
                               input int exp_abort);
        int n = 0;
        int aborts = 0;
        int finishes = 0;
        write_base      = ADDR_BITS'(base);
        write_buf_index = IDX_BITS'(idx);
        write_len       = ADDR_BITS'(len);
        rd_data_count   = '0;
        write_req       = 1'b1;
        do begin
            tick();
            n++;
            if (frame_abort) aborts++;
            if (write_finish) finishes++;
        end while (!write_req_ack && n < 40);
        check("ack_latency", 32'(n), 32'd4);
        check("ack_aclr", 32'(fifo_aclr), 32'd1);
        check("ack_busy", 32'(busy), 32'd1);
        check("start_abort", 32'(aborts), 32'(exp_abort));
        check("start_no_finish", 32'(finishes), 32'd0);
    endtask

    task automatic release_req();
        int n = 0;
        tick();
        write_req = 1'b0;
        do begin
            tick();
            n++;
        end while (write_req_ack && n < 40);
        check("ack_fall", 32'(n), 32'd4);
        check("aclr_fall", 32'(fifo_aclr), 32'd0);
    endtask

    task automatic run_burst(input burst_t b, input int d1, input int d2, input bit raise);
        int n = 0;
        while (!wr_burst_req && n < 64) begin
            tick();
            n++;
        end
        check("burst_req_seen", 32'(wr_burst_req), 32'd1);
        check("burst_addr", 32'(wr_burst_addr), b.addr);
        check("burst_len", 32'(wr_burst_len), b.len);
        if (raise) begin
            write_base      = ADDR_BITS'(nb_base);
            write_buf_index = IDX_BITS'(nb_idx);
            write_len       = ADDR_BITS'(nb_len);
            write_req       = 1'b1;
        end
        repeat (d1) begin
            tick();
            check("req_hold", 32'(wr_burst_req), 32'd1);
        end
        wr_burst_data_req = 1'b1;
        wr_burst_finish   = (d2 == 0);
        tick();
        wr_burst_data_req = 1'b0;
        check("req_drop", 32'(wr_burst_req), 32'd0);
        if (d2 != 0) begin
            repeat (d2 - 1) tick();
            wr_burst_finish = 1'b1;
            tick();
        end
        wr_burst_finish = 1'b0;
        check("burst_end_quiet", {30'd0, wr_burst_req, write_finish}, 32'd0);
        rd_data_count = rd_data_count - CNT_BITS'(b.len);
    endtask

    task automatic frame_body(input int unsigned base, input int unsigned idx, input int unsigned len,
                              input bit gate);
        int reqs = 0;
        int finishes = 0;
        model_frame(base, idx, len);
        if (gate && exp_q.size() > 0) begin
            rd_data_count = CNT_BITS'(exp_q[0].len - 1);
            repeat (3) begin
                tick();
                check("fill_hold", 32'(wr_burst_req), 32'd0);
            end
        end
        rd_data_count = CNT_BITS'(len);
        if (gate && exp_q.size() > 0) begin
            tick();
            check("fill_latency", 32'(wr_burst_req), 32'd1);
        end
        foreach (exp_q[i])
            run_burst(exp_q[i], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
        check("end_addr", 32'(wr_burst_addr), (exp_start + exp_words) & ADDR_MASK);
        if (exp_stall) begin
            repeat (16) begin
                tick();
                if (wr_burst_req) reqs++;
                if (write_finish) finishes++;
            end
            check("stall_no_req", 32'(reqs), 32'd0);
            check("stall_no_finish", 32'(finishes), 32'd0);
            check("stall_busy", 32'(busy), 32'd1);
        end else begin
            tick();
            check("write_finish", 32'(write_finish), 32'd1);
            tick();
            check("finish_pulse", 32'(write_finish), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst               = 1'b1;
        write_req         = 1'b0;
        write_base        = '0;
        write_buf_index   = '0;
        write_len         = '0;
        rd_data_count     = '0;
        wr_burst_data_req = 1'b0;
        wr_burst_finish   = 1'b0;
        repeat (3) tick();
        check("rst_ctrl", {26'd0, write_req_ack, write_finish, frame_abort, busy, fifo_aclr, wr_burst_req}, 32'd0);
        check("rst_len", 32'(wr_burst_len), 32'd0);
        check("rst_addr", 32'(wr_burst_addr), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Buffer 2, four full bursts from 0x100000.
        start_frame(0, 2, 1024, 0);
        release_req();
        frame_body(0, 2, 1024, 1'b1);
        check("tp1_start", exp_start, 32'h0010_0000);

        // 600 words: tail burst when enabled, otherwise a stall recovered by the next request.
        start_frame(32'h1000, 1, 600, 0);
        release_req();
        frame_body(32'h1000, 1, 600, 1'b1);
        start_frame(32'h2000, 0, 512, exp_stall ? 1 : 0);
        release_req();
        frame_body(32'h2000, 0, 512, 1'b0);

        // Index 3 clamps to buffer 2 of 3.
        start_frame(32'h123, 3, 256, 0);
        release_req();
        frame_body(32'h123, 3, 256, 1'b0);
        check("clamp_start", exp_start, 32'h0010_0123);

        // Empty frame finishes without a burst.
        start_frame(32'h40, 0, 0, 0);
        release_req();
        frame_body(32'h40, 0, 0, 1'b0);

        // New request during burst 2 of 4.
        start_frame(0, 0, 1024, 0);
        release_req();
        model_frame(0, 0, 1024);
        rd_data_count = CNT_BITS'(1024);
        nb_base = 32'h7f_ff00;
        nb_idx  = 1;
        nb_len  = 512;
        run_burst(exp_q[0], 1, 1, 1'b0);
        run_burst(exp_q[1], 0, 6, 1'b1);
        check("abort_pulse", 32'(frame_abort), 32'd1);
        check("abort_no_finish", 32'(write_finish), 32'd0);
        tick();
        check("abort_ack", {30'd0, write_req_ack, fifo_aclr}, 32'd3);
        check("abort_pulse_end", 32'(frame_abort), 32'd0);
        release_req();
        frame_body(nb_base, nb_idx, nb_len, 1'b0);

        // Reset while a burst is outstanding.
        start_frame(32'h500, 1, 768, 0);
        release_req();
        rd_data_count = CNT_BITS'(768);
        begin
            int n = 0;
            while (!wr_burst_req && n < 64) begin
                tick();
                n++;
            end
        end
        check("pre_rst_req", 32'(wr_burst_req), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_ctrl", {26'd0, write_req_ack, write_finish, frame_abort, busy, fifo_aclr, wr_burst_req}, 32'd0);
        check("rst_async_len", 32'(wr_burst_len), 32'd0);
        check("rst_async_addr", 32'(wr_burst_addr), 32'd0);
        tick();
        rst = 1'b0;
        repeat (2) tick();
        check("post_rst_idle", 32'(busy), 32'd0);

        // Randomised frames.
        for (int f = 0; f < 6; f++) begin
            int unsigned base;
            int unsigned idx;
            int unsigned len;
            base = $urandom & ADDR_MASK;
            idx  = $urandom_range(0, 3);
            len  = TAIL_EN ? $urandom_range(0, 1100) : BURST_SIZE * $urandom_range(0, 4);
            start_frame(base, idx, len, 0);
            release_req();
            frame_body(base, idx, len, f[0]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
